// File: rtl/level_debounce_if.sv
// rtl/level_debounce_if.sv - level input / debounced output bundle for level_debounce
//
// Purpose: groups the raw level input and the debounced status outputs so the
// debouncer and its driver share one port.
// Signals:
//   D          raw asynchronous level (switch or pin), may bounce
//   Q          synchronized, debounced level
//   busy       1 while a candidate level change is being qualified
//   glitch_cnt saturating count of aborted qualifications
// Modports:
//   master     drives D, observes Q/busy/glitch_cnt
//   slave      the debouncer: samples D, drives Q/busy/glitch_cnt
interface level_debounce_if;
  logic       D;
  logic       Q;
  logic       busy;
  logic [7:0] glitch_cnt;

  modport master (output D, input Q, input busy, input glitch_cnt);
  modport slave  (input D, output Q, output busy, output glitch_cnt);
endinterface

// File: rtl/level_debounce.sv
// rtl/level_debounce.sv - synchronizer plus 4-state debouncer for a bouncing level
//
// Purpose: brings an asynchronous level into the clk domain through a
// SYNC_STAGES flop chain, then only lets Q follow it after DB_CYCLES
// consecutive identical synchronized samples. Aborted qualifications are
// counted in a saturating 8-bit glitch counter.
// Ports:
//   clk        rising-edge clock for all state
//   rst        asynchronous reset, active low (0 = reset)
//   bus.D      raw level in
//   bus.Q      debounced level out (flop)
//   bus.busy   qualification in progress (flop)
//   bus.glitch_cnt  aborted qualification count, saturates at 255 (flop)
module level_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic             clk,
  input  logic             rst,
  level_debounce_if.slave  bus
);

  localparam int             CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_ZERO = '0;
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [7:0]     GL_MAX   = 8'hFF;

  typedef enum logic [1:0] {
    ST_LO  = 2'd0,
    CHK_HI = 2'd1,
    ST_HI  = 2'd2,
    CHK_LO = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          q, q_nxt;
  logic          busy, busy_nxt;
  logic [7:0]    glitch, glitch_nxt;
  logic          abort;

  // Synchronizer chain: bit 0 captures the raw pin, the top bit is the only
  // value the FSM ever looks at.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.D};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_LO;
      cnt    <= CNT_ZERO;
      q      <= 1'b0;
      busy   <= 1'b0;
      glitch <= 8'd0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      q      <= q_nxt;
      busy   <= busy_nxt;
      glitch <= glitch_nxt;
    end
  end

  // Next state. q/busy are computed from the next state so the registered
  // outputs line up with the state register on the same edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    abort     = 1'b0;

    unique case (state)
      ST_LO: begin
        if (s) begin
          state_nxt = CHK_HI;
          cnt_nxt   = CNT_ONE;
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_nxt = ST_LO;
          cnt_nxt   = CNT_ZERO;
          abort     = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_HI;
          cnt_nxt   = CNT_ZERO;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_HI: begin
        if (!s) begin
          state_nxt = CHK_LO;
          cnt_nxt   = CNT_ONE;
        end
      end
      CHK_LO: begin
        if (s) begin
          state_nxt = ST_HI;
          cnt_nxt   = CNT_ZERO;
          abort     = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_LO;
          cnt_nxt   = CNT_ZERO;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_LO;
        cnt_nxt   = CNT_ZERO;
      end
    endcase

    // Q is high in ST_HI and while a falling change is still being qualified.
    q_nxt      = (state_nxt == ST_HI) || (state_nxt == CHK_LO);
    busy_nxt   = (state_nxt == CHK_HI) || (state_nxt == CHK_LO);
    glitch_nxt = (abort && (glitch != GL_MAX)) ? glitch + 8'd1 : glitch;
  end

  assign bus.Q          = q;
  assign bus.busy       = busy;
  assign bus.glitch_cnt = glitch;

endmodule

// File: tb/tb_level_debounce.sv
// tb/tb_level_debounce.sv - randomized self-checking bench for level_debounce
module tb_level_debounce;

  localparam int SYNC_STAGES = 2;
  localparam int DB_CYCLES   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  level_debounce_if bus ();

  level_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DB_CYCLES  (DB_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int q_rises  = 0;

  always @(posedge bus.Q) q_rises++;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: pin samples are delayed SYNC_STAGES edges, then Q follows
  // only after a run of DB_CYCLES samples differing from Q; a shorter run that
  // ends is one glitch.
  bit dly[$];
  bit m_q;
  int m_run;
  int m_glitch;

  task automatic model_reset();
    dly.delete();
    for (int i = 0; i < SYNC_STAGES; i++) dly.push_back(1'b0);
    m_q      = 1'b0;
    m_run    = 0;
    m_glitch = 0;
  endtask

  task automatic step(input string tag);
    bit v;
    @(posedge clk);
    v = dly.pop_front();
    dly.push_back(bus.D);
    if (v != m_q) begin
      m_run++;
      if (m_run == DB_CYCLES) begin
        m_q   = v;
        m_run = 0;
      end
    end else begin
      if (m_run > 0 && m_glitch < 255) m_glitch++;
      m_run = 0;
    end
    #1;
    check({tag, ".Q"}, int'(bus.Q), int'(m_q));
    check({tag, ".busy"}, int'(bus.busy), int'(m_run > 0));
    check({tag, ".glitch"}, int'(bus.glitch_cnt), m_glitch);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  edges;
    int  busy_edges;
    int  rise_at;
    int  r0;
    int  busy_seen;
    bit  lvl;
    int  len;

    bus.D = 1'b0;
    model_reset();
    #1 rst = 1'b0;
    #2;
    check("rst.Q", int'(bus.Q), 0);
    check("rst.busy", int'(bus.busy), 0);
    check("rst.glitch", int'(bus.glitch_cnt), 0);
    #9 rst = 1'b1;

    // Clean rise: count edges from the first one that samples D=1.
    bus.D = 1'b1;
    rise_at = 0;
    busy_edges = 0;
    for (int i = 1; i <= 20 && rise_at == 0; i++) begin
      step("rise");
      if (bus.busy) busy_edges++;
      if (bus.Q) rise_at = i;
    end
    check("rise.latency", rise_at, SYNC_STAGES + DB_CYCLES);
    check("rise.busy_cycles", busy_edges, DB_CYCLES - 1);
    for (int i = 0; i < 4; i++) step("hold_hi");

    // 20 ns low dip while high.
    bus.D = 1'b0;
    step("dip");
    step("dip");
    bus.D = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step("dip_back");
      if (bus.busy) busy_seen = 1;
    end
    check("dip.busy_pulse", busy_seen, 1);
    check("dip.glitch", int'(bus.glitch_cnt), 1);
    check("dip.Q", int'(bus.Q), 1);

    // Random runs of levels, some long enough to qualify and some not.
    for (int r = 0; r < 60; r++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, DB_CYCLES + 3);
      bus.D = lvl;
      for (int i = 0; i < len; i++) step("rand");
    end

    // Settle low, then 0->1 with three bounces: exactly one Q rise.
    bus.D = 1'b0;
    for (int i = 0; i < 12; i++) step("settle_lo");
    r0 = q_rises;
    for (int b = 0; b < 3; b++) begin
      bus.D = 1'b1;
      step("bounce");
      bus.D = 1'b0;
      step("bounce");
    end
    bus.D = 1'b1;
    for (int i = 0; i < 12; i++) step("bounce_settle");
    check("bounce.rises", q_rises - r0, 1);

    // Fast toggling from Q=0 saturates the glitch counter.
    bus.D = 1'b0;
    for (int i = 0; i < 12; i++) step("pre_sat");
    for (int t = 0; t < 300; t++) begin
      bus.D = 1'b1;
      step("sat");
      bus.D = 1'b0;
      step("sat");
    end
    check("sat.glitch", int'(bus.glitch_cnt), 255);
    check("sat.Q", int'(bus.Q), 0);

    // Asynchronous reset mid CHK_HI, then recovery with D held high.
    for (int i = 0; i < 8; i++) step("pre_arst");
    bus.D = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 10 && busy_seen == 0; i++) begin
      step("arst_wait");
      if (bus.busy) busy_seen = 1;
    end
    check("arst.reached_busy", busy_seen, 1);
    #2 rst = 1'b0;
    #1;
    check("arst.Q", int'(bus.Q), 0);
    check("arst.busy", int'(bus.busy), 0);
    check("arst.glitch", int'(bus.glitch_cnt), 0);
    model_reset();
    #2 rst = 1'b1;
    rise_at = 0;
    for (int i = 1; i <= 20 && rise_at == 0; i++) begin
      step("arst_rise");
      if (bus.Q) rise_at = i;
    end
    check("arst.latency", rise_at, SYNC_STAGES + DB_CYCLES);
    edges = 0;
    for (int i = 0; i < 4; i++) begin
      step("arst_hold");
      edges++;
    end
    check("arst.glitch_after", int'(bus.glitch_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/level_debounce.md
LEVEL_DEBOUNCE -- requirements
Module: level_debounce

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2, number of synchronizer flops on D (legal range 2..4).
REQ-002 SHALL provide parameter DB_CYCLES, default 4, consecutive stable synchronized samples required to change Q (legal range 2..255).
REQ-003 SHALL provide port clk  input  1  single rising-edge clock for all state.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 SHALL provide port D  input  1  raw asynchronous level (switch or pin), may bounce.
REQ-006 SHALL provide port Q  output  1  registered, synchronized, debounced level, driving the downstream level_det D input directly.
REQ-007 SHALL provide port busy  output  1  registered, 1 while a candidate level change is being qualified.
REQ-008 SHALL provide port glitch_cnt  output  8  registered, saturating count of aborted qualifications.

Function
REQ-009 SHALL pass D through a chain of SYNC_STAGES flops; the last stage output is s. Only s is used by the FSM.
REQ-010 SHALL implement a 4-state FSM: ST_LO, CHK_HI, ST_HI, CHK_LO, plus a qualification counter cnt of width ceil(log2(DB_CYCLES+1)).
REQ-011 ST_LO: Q=0, busy=0. s=1 sampled -> CHK_HI, cnt=1. Otherwise hold.
REQ-012 CHK_HI: busy=1.
- s=0 -> ST_LO, cnt=0, glitch_cnt+1.
- s=1 and cnt==DB_CYCLES-1 -> ST_HI, Q=1, cnt=0.
- Otherwise cnt+1.
REQ-013 ST_HI: Q=1, busy=0. s=0 sampled -> CHK_LO, cnt=1. Otherwise hold.
REQ-014 CHK_LO: busy=1, mirror of REQ-012 with polarities swapped.
- s=1 -> ST_HI, glitch_cnt+1.
- s=0 and cnt==DB_CYCLES-1 -> ST_LO, Q=0.
REQ-015 Q changes on the DB_CYCLES-th consecutive edge at which s holds the new value.
- Latency from the first edge that captures a new, stable D: SYNC_STAGES+DB_CYCLES edges (default 6).
REQ-016 Q SHALL change at most once per qualification and never on a partial count.
- Any pulse on s shorter than DB_CYCLES cycles produces no Q change.
REQ-017 glitch_cnt SHALL saturate at 255; an abort while at 255 leaves it at 255. It SHALL never wrap.
REQ-018 Q, busy and glitch_cnt SHALL be driven directly from flops, with no combinational path from D.
REQ-019 cnt SHALL never exceed DB_CYCLES-1, and SHALL be 0 in ST_LO and ST_HI.

Reset
REQ-020 While rst=0, all of the following SHALL be forced asynchronously, regardless of clk: sync flops=0, state=ST_LO, cnt=0, Q=0, busy=0, glitch_cnt=0.
REQ-021 Asserting rst mid-qualification (CHK_HI or CHK_LO) SHALL abandon the qualification without incrementing glitch_cnt.
REQ-022 If D=1 when rst releases, Q SHALL rise SYNC_STAGES+DB_CYCLES edges after release, as for a normal rising change.

Verification (clk period 10 ns, defaults)
REQ-023 Hold rst=0 for 10 ns with D=0, release, D=1 stable -> Q rises exactly 6 edges after the first edge sampling D=1; busy=1 for the 3 cycles before Q rises; glitch_cnt=0.
REQ-024 From Q=1, D=0 for 20 ns then back to 1 -> Q stays 1; busy pulses; glitch_cnt=1.
REQ-025 From Q=0, 300 bounce toggles of D with a 20 ns period -> Q stays 0; glitch_cnt=255 (saturated, no wrap).
REQ-026 Drive D=1 and assert rst while busy=1 (CHK_HI) -> Q=0, busy=0 and glitch_cnt=0 immediately, without a clk edge. Release -> Q rises 6 edges later.
REQ-027 Chain level_debounce.Q into level_det.D, and apply D as 0 -> 1 with 3 bounces, then stable -> exactly one rising-edge event is reported by level_det.
